// File: rtl/led_pkg.sv
// Shared definitions for the LED mode selector: selection width helper and
// the step-direction encodings produced from the two button press pulses.
package led_pkg;

  localparam logic [1:0] STEP_NONE = 2'b00;
  localparam logic [1:0] STEP_NEXT = 2'b01;
  localparam logic [1:0] STEP_PREV = 2'b10;

  function automatic int sel_width(input int n_src);
    return (n_src > 1) ? $clog2(n_src) : 1;
  endfunction

endpackage

// File: rtl/led_mode_sel_btn_debounce.sv
// Raw push-button conditioning: 2-flop synchroniser, consecutive-cycle
// debouncer and a registered single-cycle pulse on each accepted press.
module btn_debounce #(
  parameter int DEB_CYC = 1000
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_btn,
  output logic o_press
);

  localparam int CNT_W = $clog2(DEB_CYC + 1);

  logic             sync1;
  logic             sync2;
  logic             deb;
  logic             deb_d;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      deb     <= 1'b0;
      deb_d   <= 1'b0;
      cnt     <= '0;
      o_press <= 1'b0;
    end else begin
      sync1 <= i_btn;
      sync2 <= sync1;
      deb_d <= deb;
      // Only a run of DEB_CYC differing cycles moves the accepted level.
      if (sync2 != deb) begin
        if (cnt == CNT_W'(DEB_CYC - 1)) begin
          deb <= sync2;
          cnt <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
      o_press <= deb & ~deb_d;
    end
  end

endmodule

// File: rtl/led_mode_sel.sv
// Button-stepped LED source selector with wrap-around selection and a
// blanking window after every change of mode.
module led_mode_sel
  import led_pkg::*;
#(
  parameter int N_LEDS    = 4,
  parameter int N_SRC     = 4,
  parameter int SEL_W     = sel_width(N_SRC),
  parameter int DEB_CYC   = 1000,
  parameter int BLANK_CYC = 8,
  parameter int RESET_SEL = 0
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_btn_next,
  input  logic                    i_btn_prev,
  input  logic [N_SRC*N_LEDS-1:0] i_src_leds,
  output logic [N_LEDS-1:0]       o_leds,
  output logic [SEL_W-1:0]        o_sel,
  output logic                    o_blank
);

  localparam int CNT_W = (BLANK_CYC > 0) ? $clog2(BLANK_CYC + 1) : 1;

  logic              press_next;
  logic              press_prev;
  logic [1:0]        step;
  logic              changed;
  logic [SEL_W-1:0]  sel_nxt;
  logic [CNT_W-1:0]  blank_cnt;
  logic [CNT_W-1:0]  blank_cnt_nxt;
  logic [N_LEDS-1:0] pattern;

  btn_debounce #(.DEB_CYC(DEB_CYC)) u_next (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_btn   (i_btn_next),
    .o_press (press_next)
  );

  btn_debounce #(.DEB_CYC(DEB_CYC)) u_prev (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_btn   (i_btn_prev),
    .o_press (press_prev)
  );

  assign step = {press_prev, press_next};

  // Simultaneous presses encode as neither direction and cancel out.
  always_comb begin
    sel_nxt = o_sel;
    changed = 1'b0;
    case (step)
      STEP_NEXT: begin
        sel_nxt = (o_sel == SEL_W'(N_SRC - 1)) ? '0 : o_sel + SEL_W'(1);
        changed = 1'b1;
      end
      STEP_PREV: begin
        sel_nxt = (o_sel == '0) ? SEL_W'(N_SRC - 1) : o_sel - SEL_W'(1);
        changed = 1'b1;
      end
      default: begin
        sel_nxt = o_sel;
        changed = 1'b0;
      end
    endcase
  end

  always_comb begin
    blank_cnt_nxt = '0;
    if (changed && (BLANK_CYC > 0)) begin
      blank_cnt_nxt = CNT_W'(BLANK_CYC);
    end else if (blank_cnt != '0) begin
      blank_cnt_nxt = blank_cnt - CNT_W'(1);
    end
  end

  always_comb begin
    pattern = '0;
    for (int k = 0; k < N_SRC; k++) begin
      if (sel_nxt == SEL_W'(k)) begin
        pattern = i_src_leds[k*N_LEDS +: N_LEDS];
      end
    end
  end

  // Outputs are computed from next-state values so they all move on one edge.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_sel     <= SEL_W'(RESET_SEL);
      blank_cnt <= '0;
      o_blank   <= 1'b0;
      o_leds    <= '0;
    end else begin
      o_sel     <= sel_nxt;
      blank_cnt <= blank_cnt_nxt;
      o_blank   <= (blank_cnt_nxt != '0);
      o_leds    <= (blank_cnt_nxt != '0) ? '0 : pattern;
    end
  end

endmodule

// File: tb/tb_led_mode_sel.sv
// Scoreboard bench for led_mode_sel: stimulus queues cycle-stamped expected
// outputs, a negedge monitor pops and compares them when their cycle arrives.
module tb_led_mode_sel;

  typedef struct {
    int         cyc;
    int         sel;
    logic       blank;
    logic [3:0] leds;
  } exp_t;

  logic        clock;
  logic        reset;
  logic        btn_next;
  logic        btn_prev;
  logic [15:0] src_leds;
  logic [3:0]  leds;
  logic [1:0]  sel;
  logic        blank;

  int   cyc;
  int   n_checks;
  int   n_fail;
  exp_t sb[$];

  led_mode_sel #(
    .N_LEDS    (4),
    .N_SRC     (4),
    .DEB_CYC   (4),
    .BLANK_CYC (3),
    .RESET_SEL (0)
  ) dut (
    .i_clock    (clock),
    .i_reset    (reset),
    .i_btn_next (btn_next),
    .i_btn_prev (btn_prev),
    .i_src_leds (src_leds),
    .o_leds     (leds),
    .o_sel      (sel),
    .o_blank    (blank)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [3:0] led_of(input int s);
    logic [3:0] one;
    one = 4'h1;
    return one << s;
  endfunction

  task automatic push_exp(input int c, input int s, input logic b, input logic [3:0] l);
    exp_t x;
    x.cyc   = c;
    x.sel   = s;
    x.blank = b;
    x.leds  = l;
    sb.push_back(x);
  endtask

  task automatic check_output(input string name, input int c, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s at cycle %0d: actual=%0h required=%0h", name, c, act, req);
    end
  endtask

  // Monitor: compares every expectation whose cycle stamp has been reached.
  always @(negedge clock) begin
    exp_t x;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      x = sb.pop_front();
      check_output("o_sel",   x.cyc, 32'(sel),   32'(x.sel));
      check_output("o_blank", x.cyc, 32'(blank), 32'(x.blank));
      check_output("o_leds",  x.cyc, 32'(leds),  32'(x.leds));
    end
  end

  // A clean press issued at negedge e lands on o_sel at edge e+8.
  task automatic step_expect(input int e, input int old_sel, input int new_sel);
    push_exp(e + 7,  old_sel, 1'b0, led_of(old_sel));
    push_exp(e + 8,  new_sel, 1'b1, 4'h0);
    push_exp(e + 10, new_sel, 1'b1, 4'h0);
    push_exp(e + 11, new_sel, 1'b0, led_of(new_sel));
  endtask

  task automatic apply_stimulus(input logic nxt, input logic prv, input int hold, input int gap);
    btn_next = nxt;
    btn_prev = prv;
    repeat (hold) @(negedge clock);
    btn_next = 1'b0;
    btn_prev = 1'b0;
    repeat (gap) @(negedge clock);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int         e;
    logic [8:0] bounce;

    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    btn_next = 1'b0;
    btn_prev = 1'b0;
    src_leds = 16'h8421;

    // Reset values, then the first source one cycle after release.
    repeat (2) @(negedge clock);
    e = cyc;
    push_exp(e + 1, 0, 1'b0, 4'h0);
    push_exp(e + 2, 0, 1'b0, 4'h1);
    push_exp(e + 4, 0, 1'b0, 4'h1);
    @(negedge clock);
    reset = 1'b1;
    repeat (5) @(negedge clock);

    // Long hold of next: one step only.
    e = cyc;
    step_expect(e, 0, 1);
    push_exp(e + 20, 1, 1'b0, 4'h2);
    apply_stimulus(1'b1, 1'b0, 20, 10);

    // prev back to 0, then wrap to 3.
    e = cyc;
    step_expect(e, 1, 0);
    apply_stimulus(1'b0, 1'b1, 6, 10);
    e = cyc;
    step_expect(e, 0, 3);
    apply_stimulus(1'b0, 1'b1, 6, 10);

    // Four next presses walk 3 -> 0 -> 1 -> 2 -> 3.
    for (int i = 0; i < 4; i++) begin
      e = cyc;
      step_expect(e, (i + 3) % 4, i);
      apply_stimulus(1'b1, 1'b0, 6, 10);
    end

    // A 3-cycle glitch is rejected.
    e = cyc;
    push_exp(e + 10, 3, 1'b0, 4'h8);
    push_exp(e + 14, 3, 1'b0, 4'h8);
    apply_stimulus(1'b1, 1'b0, 3, 14);

    // Bounce train of 1-3 cycle pulses, then a stable level: one step.
    e = cyc;
    push_exp(e + 12, 3, 1'b0, 4'h8);
    bounce = 9'b011101101;
    for (int i = 0; i < 9; i++) begin
      btn_next = bounce[i];
      @(negedge clock);
    end
    e = cyc;
    step_expect(e, 3, 0);
    push_exp(e + 18, 0, 1'b0, 4'h1);
    apply_stimulus(1'b1, 1'b0, 6, 14);

    // Both buttons on the same edge cancel.
    e = cyc;
    push_exp(e + 8,  0, 1'b0, 4'h1);
    push_exp(e + 9,  0, 1'b0, 4'h1);
    push_exp(e + 12, 0, 1'b0, 4'h1);
    apply_stimulus(1'b1, 1'b1, 6, 10);

    // prev lands one cycle after next, inside the blank window: window restarts.
    e = cyc;
    push_exp(e + 7,  0, 1'b0, 4'h1);
    push_exp(e + 8,  1, 1'b1, 4'h0);
    push_exp(e + 9,  0, 1'b1, 4'h0);
    push_exp(e + 11, 0, 1'b1, 4'h0);
    push_exp(e + 12, 0, 1'b0, 4'h1);
    btn_next = 1'b1;
    @(negedge clock);
    btn_prev = 1'b1;
    repeat (5) @(negedge clock);
    btn_next = 1'b0;
    @(negedge clock);
    btn_prev = 1'b0;
    repeat (10) @(negedge clock);

    // Reset asserted between edges mid-blank clears outputs without a clock.
    e = cyc;
    push_exp(e + 8,  1, 1'b1, 4'h0);
    push_exp(e + 9,  0, 1'b0, 4'h0);
    push_exp(e + 11, 0, 1'b0, 4'h0);
    push_exp(e + 12, 0, 1'b0, 4'h1);
    btn_next = 1'b1;
    repeat (6) @(negedge clock);
    btn_next = 1'b0;
    repeat (2) @(negedge clock);
    @(posedge clock);
    #2;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (4) @(negedge clock);

    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL scoreboard_drain: actual=%0d pending required=0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
